// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder.
//   Size encodings match funct3[1:0] of RISC-V loads and stores.
//   FSM state encodings are plain localparams for legacy-tool compatibility.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Copy the low byte/half of store data into every lane it could land in, so the
  // byte enables alone decide which lanes get written.
  function automatic logic [31:0] replicate_wdata(input logic [1:0]  size,
                                                  input logic [31:0] wdata);
    logic [31:0] r;
    r = wdata;
    if (size == SZ_BYTE) begin
      r = {4{wdata[7:0]}};
    end else if (size == SZ_HALF) begin
      r = {2{wdata[15:0]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath for the data-memory responder (purely combinational).
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   addr_lo     : byte offset within the word
//   wdata       : store data, LSB-aligned
//   old_word    : current contents of the addressed word
//   is_unsigned : loads only, 1 = zero-extend
//   byte_en     : lanes a store would write
//   merged_word : old_word with enabled lanes replaced by store data
//   load_data   : selected lane(s), extended to 32 bits
//   misalign    : illegal size or offset not aligned to the size
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] old_word,
  input  logic        is_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] merged_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] repl;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign repl       = replicate_wdata(size, wdata);
  assign byte_shift = old_word >> {addr_lo, 3'b000};
  assign half_shift = old_word >> {addr_lo[1], 4'b0000};
  assign sel_byte   = byte_shift[7:0];
  assign sel_half   = half_shift[15:0];

  always_comb begin
    byte_en   = 4'b0000;
    misalign  = 1'b0;
    load_data = 32'h0;
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        load_data = is_unsigned ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = is_unsigned ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        misalign  = (addr_lo != 2'b00);
        byte_en   = 4'b1111;
        load_data = old_word;
      end
      default: begin
        misalign = 1'b1;
      end
    endcase
  end

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = repl[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency memory-side responder for the core's load/store port.
// One request is outstanding at a time; the response is presented LATENCY cycles after
// the accepting edge and held until the core takes it.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address, word index = req_addr[31:2]
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : loads only, 1 = zero-extend
//   req_wdata           : store data, LSB-aligned
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : misaligned, out-of-range or illegal size
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2    // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        enter_resp;

  logic        cap_write_q;
  logic [31:0] cap_addr_q;
  logic [1:0]  cap_size_q;
  logic        cap_unsigned_q;
  logic [31:0] cap_wdata_q;

  logic        op_write;
  logic [31:0] op_addr;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_wdata;
  logic [IDX_W-1:0] op_idx;
  logic        op_range_err;
  logic        op_err;

  logic [31:0] old_word;
  logic [3:0]  lane_be;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic        misalign;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=1 the edge that accepts is also the edge that enters RESP, so the
  // live request fields feed the datapath while idle; otherwise the captured copy does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      op_write    = req_write;
      op_addr     = req_addr;
      op_size     = req_size;
      op_unsigned = req_unsigned;
      op_wdata    = req_wdata;
    end else begin
      op_write    = cap_write_q;
      op_addr     = cap_addr_q;
      op_size     = cap_size_q;
      op_unsigned = cap_unsigned_q;
      op_wdata    = cap_wdata_q;
    end
  end

  assign op_idx       = op_addr[IDX_W+1:2];
  assign op_range_err = ({2'b00, op_addr[31:2]} >= DEPTH_WORDS);
  assign old_word     = op_range_err ? 32'h0 : mem[op_idx];
  assign op_err       = op_range_err | misalign;

  dmem_lane_unit u_lane_unit (
    .size        (op_size),
    .addr_lo     (op_addr[1:0]),
    .wdata       (op_wdata),
    .old_word    (old_word),
    .is_unsigned (op_unsigned),
    .byte_en     (lane_be),
    .merged_word (merged_word),
    .load_data   (load_data),
    .misalign    (misalign)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = CNT_LOAD;
          if (LATENCY <= 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // Leave on the edge where the counter reaches zero.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      cap_write_q    <= 1'b0;
      cap_addr_q     <= 32'h0;
      cap_size_q     <= SZ_BYTE;
      cap_unsigned_q <= 1'b0;
      cap_wdata_q    <= 32'h0;
      rsp_rdata_q    <= 32'h0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_write_q    <= req_write;
        cap_addr_q     <= req_addr;
        cap_size_q     <= req_size;
        cap_unsigned_q <= req_unsigned;
        cap_wdata_q    <= req_wdata;
      end
      if (enter_resp) begin
        rsp_err_q   <= op_err;
        rsp_rdata_q <= (op_write || op_err) ? 32'h0 : load_data;
      end
    end
  end

  // Storage is never cleared; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_write && !op_err && (lane_be != 4'b0000)) begin
      mem[op_idx] <= merged_word;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
